post_proc_combiner: RTL and testbench

Parametrised N-channel post-processing combiner for the 100 MHz output path. It accepts `N_CH` data words per beat and reduces them through a registered adder tree. One result word per beat is produced in a runtime-selectable mode: wrapping sum, mean, or saturating sum. Valid/ready handshaking on both sides and an overflow event counter let it sit between the TDM burst demux and the top-level data output port.

---
 rtl/post_proc_combiner_pkg.sv | 26 ++
 rtl/post_proc_combiner_if.sv | 38 +++
 rtl/post_proc_combiner_add_stage.sv | 65 ++++++
 rtl/post_proc_combiner.sv | 143 ++++++++++++++
 tb/tb_post_proc_combiner.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/post_proc_combiner_pkg.sv
`default_nettype none
// ============================================================================
// Package     : post_proc_pkg
// Description : Shared types and helpers for the post-processing combiner.
//               pp_mode_e enumerates the output formats (code 3 is not a
//               member and is handled as PP_WRAP). pp_lvl() gives the number
//               of adder-tree levels for a channel count.
// Revision    : 1.0 - initial release
// ============================================================================
package post_proc_pkg;

    localparam int PP_MODE_W = 2;

    typedef enum logic [PP_MODE_W-1:0] {
        PP_WRAP = 2'd0,
        PP_MEAN = 2'd1,
        PP_SAT  = 2'd2
    } pp_mode_e;

    // Number of pairwise-add levels needed to reduce n words to one.
    function automatic int pp_lvl(input int n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/post_proc_combiner_if.sv
`default_nettype none
// ============================================================================
// Interface   : post_proc_combiner_if
// Description : Beat-in / result-out handshake bundle for post_proc_combiner.
//   in_valid  : input beat valid           (master -> slave)
//   in_ready  : slave can take a beat      (slave  -> master)
//   din       : N_CH words, channel k at [k*DATA_W +: DATA_W]
//   mode      : output format, travels with the beat
//   out_valid : result valid               (slave  -> master)
//   out_ready : result accepted downstream (master -> slave)
//   dout      : result word
// Revision    : 1.0 - initial release
// ============================================================================
interface post_proc_combiner_if
    import post_proc_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N_CH*DATA_W-1:0]   din;
    logic [PP_MODE_W-1:0]     mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        dout;

    modport slave (
        input  in_valid, din, mode, out_ready,
        output in_ready, out_valid, dout
    );

    modport master (
        output in_valid, din, mode, out_ready,
        input  in_ready, out_valid, dout
    );
endinterface
`default_nettype wire

// File: rtl/post_proc_combiner_add_stage.sv
`default_nettype none
// ============================================================================
// Module      : post_proc_add_stage
// Description : One adder-tree level. Adds adjacent input word pairs into
//               registered sums one bit wider, and carries the beat's valid
//               and mode alongside. Everything loads only when adv_i is high.
// Ports       : clk, rst_n (async, active-low), adv_i (global advance),
//               valid_i/mode_i/data_i (IN_CNT words of IN_W bits),
//               valid_o/mode_o/data_o (IN_CNT/2 words of IN_W+1 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module post_proc_add_stage
    import post_proc_pkg::*;
#(
    parameter int IN_CNT = 2,
    parameter int IN_W   = 16
) (
    input  wire logic                                   clk,
    input  wire logic                                   rst_n,
    input  wire logic                                   adv_i,
    input  wire logic                                   valid_i,
    input  wire logic [PP_MODE_W-1:0]                   mode_i,
    input  wire logic [IN_CNT*IN_W-1:0]                 data_i,
    output      logic                                   valid_o,
    output      logic [PP_MODE_W-1:0]                   mode_o,
    output      logic [(IN_CNT/2)*(IN_W+1)-1:0]         data_o
);
    localparam int OUT_CNT = IN_CNT / 2;
    localparam int OUT_W   = IN_W + 1;

    logic                       valid_q;
    logic [PP_MODE_W-1:0]       mode_q;
    logic [OUT_CNT*OUT_W-1:0]   sum_d;
    logic [OUT_CNT*OUT_W-1:0]   sum_q;

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < OUT_CNT; k++) begin
            sum_d[k*OUT_W +: OUT_W] = {1'b0, data_i[(2*k)*IN_W   +: IN_W]}
                                    + {1'b0, data_i[(2*k+1)*IN_W +: IN_W]};
        end
    end

    // Only the valid bit is reset; payload is qualified by it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (adv_i) begin
            valid_q <= valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_i) begin
            sum_q  <= sum_d;
            mode_q <= mode_i;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign data_o  = sum_q;

endmodule
`default_nettype wire

// File: rtl/post_proc_combiner.sv
`default_nettype none
// ============================================================================
// Module      : post_proc_combiner
// Description : N-channel combiner. Reduces N_CH words per beat through a
//               registered pairwise adder tree (one adder level per stage),
//               then a format stage producing wrap sum, mean or saturating
//               sum. Counts transferred results whose full sum overflowed
//               DATA_W bits. The whole pipe stalls while a result waits.
// Ports       : clk, rst_n (async, active-low)
//               bus     : post_proc_combiner_if.slave (beat in / result out)
//               clr_cnt : synchronous clear of ovf_cnt (beats increment)
//               ovf_cnt : saturating overflow-result counter
// Build macro : POST_PROC_SAT_EN - when defined, mode 2 saturates; when not,
//               mode 2 formats exactly like mode 0 (flag/counter unaffected).
// Revision    : 1.0 - initial release
// ============================================================================
module post_proc_combiner
    import post_proc_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    post_proc_combiner_if.slave     bus,
    input  wire logic               clr_cnt,
    output      logic [CNT_W-1:0]   ovf_cnt
);
    localparam int LVL   = pp_lvl(N_CH);
    localparam int SUM_W = DATA_W + LVL;

    logic                   adv;
    logic                   tail_valid;
    logic [PP_MODE_W-1:0]   tail_mode;
    logic [SUM_W-1:0]       tail_sum;
    logic                   ovf_d;
    logic [DATA_W-1:0]      dout_d;
    logic                   out_valid_q;
    logic [DATA_W-1:0]      dout_q;
    logic                   ovf_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_q;

    // Global stall: nothing moves while a result is held unaccepted.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar j = 0; j < LVL; j++) begin : g_tree
        localparam int ST_IN_CNT = N_CH >> j;
        localparam int ST_IN_W   = DATA_W + j;

        logic                                   st_valid_in;
        logic [PP_MODE_W-1:0]                   st_mode_in;
        logic [ST_IN_CNT*ST_IN_W-1:0]           st_data_in;
        logic                                   st_valid;
        logic [PP_MODE_W-1:0]                   st_mode;
        logic [(ST_IN_CNT/2)*(ST_IN_W+1)-1:0]   st_data;

        if (j == 0) begin : g_first
            assign st_valid_in = bus.in_valid;
            assign st_mode_in  = bus.mode;
            assign st_data_in  = bus.din;
        end else begin : g_chain
            assign st_valid_in = g_tree[j-1].st_valid;
            assign st_mode_in  = g_tree[j-1].st_mode;
            assign st_data_in  = g_tree[j-1].st_data;
        end

        post_proc_add_stage #(
            .IN_CNT (ST_IN_CNT),
            .IN_W   (ST_IN_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv_i   (adv),
            .valid_i (st_valid_in),
            .mode_i  (st_mode_in),
            .data_i  (st_data_in),
            .valid_o (st_valid),
            .mode_o  (st_mode),
            .data_o  (st_data)
        );
    end

    assign tail_valid = g_tree[LVL-1].st_valid;
    assign tail_mode  = g_tree[LVL-1].st_mode;
    assign tail_sum   = g_tree[LVL-1].st_data;

    assign ovf_d = |tail_sum[SUM_W-1:DATA_W];

    // Format stage; mode code 3 falls through to the wrap result.
    always_comb begin
        dout_d = tail_sum[DATA_W-1:0];
        case (tail_mode)
            PP_MEAN: dout_d = tail_sum[SUM_W-1:LVL];
`ifdef POST_PROC_SAT_EN
            PP_SAT: begin
                if (ovf_d) begin
                    dout_d = '1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= tail_valid;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    // Clear takes priority over a simultaneous flagged transfer.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid_q && bus.out_ready && ovf_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign ovf_cnt       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_post_proc_combiner.sv
`default_nettype none
// ============================================================================
// Module      : tb_post_proc_combiner
// Description : Self-checking bench. Instance A: N_CH=2, CNT_W=16.
//               Instance B: N_CH=4, CNT_W=3 (small counter for saturation).
//               Expected results come from an arithmetic reference model of
//               the combiner's output rules (sum, mean, saturation).
//               Honours POST_PROC_SAT_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_post_proc_combiner;

    typedef struct packed {
        logic        ovf;
        logic [15:0] dout;
    } res_t;

    logic clk = 1'b0;
    logic rst_na, rst_nb;
    logic clr_a, clr_b;
    logic [15:0] ovf_a;
    logic [2:0]  ovf_b;

    always #5 clk = ~clk;

    post_proc_combiner_if #(.N_CH(2), .DATA_W(16)) a_if ();
    post_proc_combiner_if #(.N_CH(4), .DATA_W(16)) b_if ();

    post_proc_combiner #(.N_CH(2), .DATA_W(16), .CNT_W(16)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_na),
        .bus     (a_if),
        .clr_cnt (clr_a),
        .ovf_cnt (ovf_a)
    );

    post_proc_combiner #(.N_CH(4), .DATA_W(16), .CNT_W(3)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_nb),
        .bus     (b_if),
        .clr_cnt (clr_b),
        .ovf_cnt (ovf_b)
    );

    res_t        exp_a[$], exp_b[$];
    logic [15:0] got_a[$], got_b[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ovf_exp_a = 0;
    int          ovf_exp_b = 0;
    logic        r;
    logic [15:0] q;

    // Reference: plain integer sum of the channels, then the output rule.
    function automatic res_t model(input int n, input logic [63:0] d, input logic [1:0] m);
        longint s;
        res_t   res;
        s = 0;
        for (int k = 0; k < n; k++) s += longint'(d[k*16 +: 16]);
        res.ovf = (s > 65535);
        case (m)
            2'd1: res.dout = 16'(s / longint'(n));
            2'd2: begin
`ifdef POST_PROC_SAT_EN
                res.dout = res.ovf ? 16'hFFFF : 16'(s);
`else
                res.dout = 16'(s);
`endif
            end
            default: res.dout = 16'(s);
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Transfers are recorded on the negedge before the edge that takes them.
    always @(negedge clk) begin
        if (rst_na && a_if.out_valid && a_if.out_ready) got_a.push_back(a_if.dout);
        if (rst_nb && b_if.out_valid && b_if.out_ready) got_b.push_back(b_if.dout);
    end

    task automatic step_a(input logic v, input logic [31:0] d, input logic [1:0] m,
                          input logic ordy, output logic rdy, output logic [15:0] dq);
        a_if.in_valid  = v;
        a_if.din       = d;
        a_if.mode      = m;
        a_if.out_ready = ordy;
        @(negedge clk);
        rdy = a_if.in_ready;
        dq  = a_if.dout;
        if (v && rdy) exp_a.push_back(model(2, {32'h0, d}, m));
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic [63:0] d, input logic [1:0] m,
                          input logic ordy, input logic clr, output logic rdy);
        b_if.in_valid  = v;
        b_if.din       = d;
        b_if.mode      = m;
        b_if.out_ready = ordy;
        clr_b          = clr;
        @(negedge clk);
        rdy = b_if.in_ready;
        if (v && rdy) exp_b.push_back(model(4, d, m));
        @(posedge clk);
        #1;
        clr_b = 1'b0;
    endtask

    task automatic drain_a();
        logic        rr;
        logic [15:0] qq;
        repeat (6) step_a(1'b0, 32'h0, 2'd0, 1'b1, rr, qq);
        check("A_count", got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < got_a.size()) check($sformatf("A_res%0d", i), got_a[i], exp_a[i].dout);
            if (exp_a[i].ovf && ovf_exp_a != 65535) ovf_exp_a++;
        end
        check("A_ovf_cnt", ovf_a, ovf_exp_a);
        exp_a.delete();
        got_a.delete();
    endtask

    task automatic drain_b(input bit do_cnt);
        logic rr;
        repeat (7) step_b(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, rr);
        check("B_count", got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i < got_b.size()) check($sformatf("B_res%0d", i), got_b[i], exp_b[i].dout);
            if (exp_b[i].ovf && ovf_exp_b != 7) ovf_exp_b++;
        end
        if (do_cnt) check("B_ovf_cnt", ovf_b, ovf_exp_b);
        exp_b.delete();
        got_b.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d;
        logic [1:0]  m;
        logic [15:0] held;
        logic        stall;
        logic        rv;
        logic        ro;
        int          acc;
        int          cyc;

        rst_na = 1'b0; rst_nb = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        a_if.in_valid = 1'b0; a_if.din = '0; a_if.mode = '0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.din = '0; b_if.mode = '0; b_if.out_ready = 1'b1;
        held = '0;
        repeat (3) @(posedge clk);
        #1;
        check("A_rst_out_valid", a_if.out_valid, 0);
        check("A_rst_dout", a_if.dout, 0);
        check("A_rst_ovf_cnt", ovf_a, 0);
        check("B_rst_out_valid", b_if.out_valid, 0);
        @(negedge clk);
        rst_na = 1'b1; rst_nb = 1'b1;
        @(posedge clk);
        #1;

        // Basic sum and two-cycle latency.
        step_a(1'b1, {16'h0003, 16'h0004}, 2'd0, 1'b1, r, q);
        check("A_first_in_ready", r, 1);
        check("A_lat1_valid", a_if.out_valid, 0);
        step_a(1'b0, 32'h0, 2'd0, 1'b1, r, q);
        check("A_lat2_valid", a_if.out_valid, 1);
        check("A_lat2_dout", a_if.dout, 16'h0007);
        drain_a();

        // Mode 2 with overflowing sum.
        step_a(1'b1, {16'hFFFF, 16'h0002}, 2'd2, 1'b1, r, q);
        drain_a();

        // Mode change between consecutive beats.
        step_a(1'b1, {16'd8, 16'd8}, 2'd0, 1'b1, r, q);
        step_a(1'b1, {16'd8, 16'd8}, 2'd1, 1'b1, r, q);
        drain_a();

        // Back-to-back stream with a three-cycle downstream stall.
        acc = 0;
        cyc = 0;
        d = $urandom;
        m = 2'($urandom_range(0, 3));
        while (acc < 8 && cyc < 40) begin
            stall = (cyc >= 4 && cyc <= 6);
            step_a(1'b1, d, m, !stall, r, q);
            check($sformatf("A_in_ready_c%0d", cyc), r, !stall);
            if (cyc == 4) held = q;
            else if (stall) check($sformatf("A_hold_dout_c%0d", cyc), q, held);
            if (r) begin
                acc++;
                d = $urandom;
                m = 2'($urandom_range(0, 3));
            end
            cyc++;
        end
        check("A_stream_accepted", acc, 8);
        drain_a();

        // Random valid/ready traffic.
        repeat (300) begin
            rv = 1'($urandom_range(0, 1));
            ro = ($urandom_range(0, 3) != 0);
            d  = $urandom;
            m  = 2'($urandom_range(0, 3));
            step_a(rv, d, m, ro, r, q);
        end
        drain_a();

        // Reset with two beats in flight.
        step_a(1'b1, $urandom, 2'd0, 1'b1, r, q);
        step_a(1'b1, $urandom, 2'd0, 1'b1, r, q);
        a_if.in_valid = 1'b0;
        rst_na = 1'b0;
        #1;
        check("A_rst_mid_valid", a_if.out_valid, 0);
        check("A_rst_mid_cnt", ovf_a, 0);
        exp_a.delete();
        got_a.delete();
        ovf_exp_a = 0;
        @(negedge clk);
        rst_na = 1'b1;
        @(posedge clk);
        #1;
        repeat (6) step_a(1'b0, 32'h0, 2'd0, 1'b1, r, q);
        check("A_post_rst_results", got_a.size(), 0);
        check("A_post_rst_valid", a_if.out_valid, 0);

        // Four channels: mean and wrap of all-ones.
        step_b(1'b1, {16'd41, 16'd30, 16'd20, 16'd10}, 2'd1, 1'b1, 1'b0, r);
        step_b(1'b1, {4{16'hFFFF}}, 2'd0, 1'b1, 1'b0, r);
        drain_b(1'b1);

        // Push the 3-bit counter past its ceiling.
        repeat (8) begin
            m = 2'($urandom_range(0, 3));
            step_b(1'b1, {4{16'hFFFF}}, m, 1'b1, 1'b0, r);
        end
        drain_b(1'b1);

        // Clear coincides with a flagged transfer.
        step_b(1'b1, {4{16'hFFFF}}, 2'd0, 1'b0, 1'b0, r);
        repeat (4) step_b(1'b0, 64'h0, 2'd0, 1'b0, 1'b0, r);
        check("B_stalled_valid", b_if.out_valid, 1);
        check("B_stalled_cnt", ovf_b, 7);
        step_b(1'b0, 64'h0, 2'd0, 1'b1, 1'b1, r);
        check("B_clr_wins", ovf_b, 0);
        drain_b(1'b0);
        check("B_cnt_after_clr", ovf_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
